// File: rtl/adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_pkg : shared FSM encoding and sizing helpers for serial adds |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must be at least one bit wide even when there is a single nibble.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cla : 4-bit carry-lookahead adder stage                            |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign s = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cla_serial_adder : WIDTH-bit adder built from one 4-bit cla stage, |
// |                    one nibble per cycle, LSB first                 |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module cla_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / NIBBLE_W;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

   state_t              r_state;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_sum;
   logic                r_carry;
   logic                r_cout;
   logic                r_ovf;
   logic                r_busy;
   logic [CW-1:0]       r_cnt;

   logic [NIBBLE_W-1:0] w_a_nib [N];
   logic [NIBBLE_W-1:0] w_b_nib [N];
   logic [NIBBLE_W-1:0] w_nib_a;
   logic [NIBBLE_W-1:0] w_nib_b;
   logic [NIBBLE_W-1:0] w_nib_s;
   logic                w_nib_co;
   logic [WIDTH-1:0]    w_sum_next;

   // Slice operands into nibbles and merge the stage result back at slot r_cnt.
   for (genvar i = 0; i < N; i++) begin : g_nib
      assign w_a_nib[i] = r_a[i*NIBBLE_W +: NIBBLE_W];
      assign w_b_nib[i] = r_b[i*NIBBLE_W +: NIBBLE_W];
      assign w_sum_next[i*NIBBLE_W +: NIBBLE_W] =
         (r_cnt == CW'(i)) ? w_nib_s : r_sum[i*NIBBLE_W +: NIBBLE_W];
   end

   assign w_nib_a = w_a_nib[r_cnt];
   assign w_nib_b = w_b_nib[r_cnt];

   cla u_cla (
      .a    (w_nib_a),
      .b    (w_nib_b),
      .cin  (r_carry),
      .s    (w_nib_s),
      .cout (w_nib_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_nib_co;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST_NIB) begin
                  // The top nibble is being produced now, so its MSB is the sum sign.
                  r_cout  <= w_nib_co;
                  r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                             (w_nib_s[NIBBLE_W-1] != r_a[WIDTH-1]);
                  r_cnt   <= '0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// Bench for cla_serial_adder: directed literal jobs plus randomized traffic at
// WIDTH=16 and WIDTH=4, all compared against an arithmetic model every cycle.
module tb_cla_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        iv16, ir16, ov16, ordy16, cin16, cout16, ovf16, busy16;
   logic [15:0] a16, b16, sum16;
   logic        iv4, ir4, ov4, ordy4, cin4, cout4, ovf4, busy4;
   logic [3:0]  a4, b4, sum4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit done4  = 1'b0;

   cla_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16),
      .cout(cout16), .ovf(ovf16), .busy(busy16)
   );

   cla_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .out_valid(ov4), .out_ready(ordy4), .sum(sum4),
      .cout(cout4), .ovf(ovf4), .busy(busy4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state per instance: one outstanding job at most, plus last results.
   bit          outst [2];
   bit          known [2];
   int          acc   [2];
   int          jobs  [2];
   logic [15:0] e_sum [2];
   logic        e_cout[2];
   logic        e_ovf [2];
   logic [15:0] l_sum [2];
   logic        l_cout[2];
   logic        l_ovf [2];

   task automatic monitor(input int id, input int w, input logic r,
                          input logic iv, input logic ir, input logic ov,
                          input logic ordy, input logic bsy,
                          input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] s, input logic co, input logic of);
      int          n;
      int          d;
      bit          exp_ov;
      logic [15:0] m;
      logic [15:0] msk;
      logic [16:0] full;
      n      = w / 4;
      d      = cyc - acc[id];
      exp_ov = outst[id] && (d >= n + 1);
      if (known[id]) begin
         chk($sformatf("w%0d_in_ready", w), 32'(ir), 32'(!outst[id]));
         chk($sformatf("w%0d_busy", w), 32'(bsy), 32'(outst[id]));
         chk($sformatf("w%0d_out_valid", w), 32'(ov), 32'(exp_ov));
         if (!outst[id]) begin
            chk($sformatf("w%0d_idle_sum", w), 32'(s), 32'(l_sum[id]));
            chk($sformatf("w%0d_idle_cout", w), 32'(co), 32'(l_cout[id]));
            chk($sformatf("w%0d_idle_ovf", w), 32'(of), 32'(l_ovf[id]));
         end else if (exp_ov) begin
            chk($sformatf("w%0d_sum", w), 32'(s), 32'(e_sum[id]));
            chk($sformatf("w%0d_cout", w), 32'(co), 32'(e_cout[id]));
            chk($sformatf("w%0d_ovf", w), 32'(of), 32'(e_ovf[id]));
         end else begin
            // d-1 low nibbles are final; the rest still hold the previous result.
            m = (16'h1 << (4 * (d - 1))) - 16'h1;
            chk($sformatf("w%0d_partial_sum", w), 32'(s),
                32'((e_sum[id] & m) | (l_sum[id] & ~m)));
            chk($sformatf("w%0d_run_cout", w), 32'(co), 32'(l_cout[id]));
            chk($sformatf("w%0d_run_ovf", w), 32'(of), 32'(l_ovf[id]));
         end
      end
      if (r) begin
         outst[id]  = 1'b0;
         known[id]  = 1'b1;
         l_sum[id]  = '0;
         l_cout[id] = 1'b0;
         l_ovf[id]  = 1'b0;
      end else if (known[id]) begin
         if (!outst[id] && iv) begin
            msk        = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
            full       = {1'b0, a} + {1'b0, b} + 17'(c);
            outst[id]  = 1'b1;
            acc[id]    = cyc;
            e_sum[id]  = full[15:0] & msk;
            e_cout[id] = full[w];
            e_ovf[id]  = (a[w-1] == b[w-1]) && (e_sum[id][w-1] != a[w-1]);
         end else if (exp_ov && ordy) begin
            outst[id]  = 1'b0;
            l_sum[id]  = e_sum[id];
            l_cout[id] = e_cout[id];
            l_ovf[id]  = e_ovf[id];
            jobs[id]++;
         end
      end
   endtask

   always @(negedge clk) begin
      monitor(0, 16, rst, iv16, ir16, ov16, ordy16, busy16, a16, b16, cin16,
              sum16, cout16, ovf16);
      monitor(1, 4, rst, iv4, ir4, ov4, ordy4, busy4, 16'(a4), 16'(b4), cin4,
              16'(sum4), cout4, ovf4);
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic job16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] xs, input logic xc, input logic xo,
                        input int hold);
      int lat;
      a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
      ordy16 = (hold == 0);
      step();
      iv16 = 1'b0;
      lat  = 0;
      while (!ov16 && lat < 20) begin
         step();
         lat++;
      end
      chk("latency", 32'(lat), 32'd4);
      chk("lit_sum", 32'(sum16), 32'(xs));
      chk("lit_cout", 32'(cout16), 32'(xc));
      chk("lit_ovf", 32'(ovf16), 32'(xo));
      for (int i = 0; i < hold; i++) begin
         a16  = 16'($urandom);
         b16  = 16'($urandom);
         iv16 = 1'($urandom % 2);
         step();
         chk("bp_out_valid", 32'(ov16), 32'd1);
         chk("bp_in_ready", 32'(ir16), 32'd0);
         chk("bp_sum", 32'(sum16), 32'(xs));
         chk("bp_cout", 32'(cout16), 32'(xc));
         chk("bp_ovf", 32'(ovf16), 32'(xo));
      end
      iv16   = 1'b0;
      ordy16 = 1'b1;
      step();
      ordy16 = 1'b0;
      chk("valid_drop", 32'(ov16), 32'd0);
      chk("ready_back", 32'(ir16), 32'd1);
   endtask

   // WIDTH=4 traffic runs alongside the 16-bit sequence.
   initial begin
      int k;
      iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; ordy4 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      k = 0;
      while (jobs[1] < 1000 && k < 20000) begin
         iv4   = 1'(($urandom % 10) != 0);
         a4    = 4'($urandom);
         b4    = 4'($urandom);
         cin4  = 1'($urandom % 2);
         ordy4 = 1'(($urandom % 10) < 7);
         step();
         k++;
      end
      iv4   = 1'b0;
      ordy4 = 1'b1;
      done4 = 1'b1;
   end

   initial begin
      int k;
      int start;
      rst = 1'b1;
      iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; ordy16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(ir16), 32'd1);
      chk("rst_out_valid", 32'(ov16), 32'd0);
      chk("rst_sum", 32'(sum16), 32'd0);
      chk("rst_cout", 32'(cout16), 32'd0);
      chk("rst_ovf", 32'(ovf16), 32'd0);
      chk("rst_busy", 32'(busy16), 32'd0);
      rst = 1'b0;
      step();

      job16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
      job16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      job16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      job16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
      job16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
      job16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 5);

      // Abort a job mid-run.
      a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b0; iv16 = 1'b1; ordy16 = 1'b1;
      step();
      iv16 = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_out_valid", 32'(ov16), 32'd0);
      chk("abort_in_ready", 32'(ir16), 32'd1);
      chk("abort_sum", 32'(sum16), 32'd0);
      chk("abort_cout", 32'(cout16), 32'd0);
      chk("abort_ovf", 32'(ovf16), 32'd0);
      chk("abort_busy", 32'(busy16), 32'd0);
      job16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

      start = jobs[0];
      k = 0;
      while (jobs[0] < start + 1000 && k < 30000) begin
         iv16   = 1'(($urandom % 10) != 0);
         a16    = 16'($urandom);
         b16    = 16'($urandom);
         if (($urandom % 16) == 0) begin
            a16 = 16'hFFFF;
            b16 = 16'hFFFF;
         end
         cin16  = 1'($urandom % 2);
         ordy16 = 1'(($urandom % 10) < 7);
         step();
         k++;
      end
      chk("random16_jobs", 32'(jobs[0] >= start + 1000), 32'd1);
      iv16   = 1'b0;
      ordy16 = 1'b1;

      k = 0;
      while (!done4 && k < 20000) begin
         step();
         k++;
      end
      chk("random4_done", 32'(done4), 32'd1);
      chk("random4_jobs", 32'(jobs[1] >= 1000), 32'd1);
      repeat (8) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
